router_1xn_buf: RTL and testbench

Parametrised 1-to-N packet-less router with per-output FIFO buffering. Accepts one data beat per cycle on a valid/ready input, steers it by address to one of NUM_PORTS outputs, and queues it in that output's FIFO. A stalled output therefore only back-pressures traffic addressed to it. Sits between a single upstream producer and NUM_PORTS independent consumers, and replaces the unbuffered 1x4 router where consumers stall.

---
 rtl/router_pkg.sv | 12 +
 rtl/router_fifo.sv | 63 ++++++
 rtl/router_1xn_buf.sv | 75 +++++++
 tb/tb_router_1xn_buf.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared constants and helpers for the 1xN buffered router
package router_pkg;

  localparam int ROUTER_MAX_PORTS = 16;
  localparam int DROP_CNT_WIDTH   = 16;

  // Low bit index of a port's slice within a flattened per-port bus.
  function automatic int port_slice(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/router_fifo.sv
// rtl/router_fifo.sv - first-word-fall-through FIFO, one per router output
module router_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] head;
  logic                  do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                   (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head    = mem_q[rd_ptr_q[IDX_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    hold_d   = hold_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      hold_d   = head;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      hold_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      hold_q   <= hold_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[IDX_W-1:0]] <= data_i;
  end

  // An empty FIFO keeps presenting the last beat it delivered.
  assign data_o = empty_o ? hold_q : head;

endmodule

// File: rtl/router_1xn_buf.sv
// rtl/router_1xn_buf.sv - 1-to-N router with per-output FWFT buffering
// ROUTER_DROP_CNT_EN adds a saturating counter of dropped out-of-range beats.
module router_1xn_buf
  import router_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int NUM_PORTS  = 4,
  parameter  int FIFO_DEPTH = 4,
  localparam int ADDR_WIDTH = $clog2(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_WIDTH-1:0]           din,
  input  logic [ADDR_WIDTH-1:0]           addr,
  input  logic                            valid_in,
  output logic                            ready_out,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] dout,
  output logic [NUM_PORTS-1:0]            valid_out,
  input  logic [NUM_PORTS-1:0]            ready_in
`ifdef ROUTER_DROP_CNT_EN
  ,
  output logic [DROP_CNT_WIDTH-1:0]       drop_cnt
`endif
);

  logic [NUM_PORTS-1:0] port_sel, full, empty, push, pop;
  logic                 in_range, sel_full;

  always_comb begin
    port_sel = '0;
    for (int k = 0; k < NUM_PORTS; k++) port_sel[k] = (addr == ADDR_WIDTH'(k));
  end

  // Out-of-range addresses select no port, so they are always accepted.
  assign in_range  = |port_sel;
  assign sel_full  = |(port_sel & full);
  assign ready_out = !rst && !sel_full;
  assign push      = {NUM_PORTS{valid_in && ready_out}} & port_sel;
  assign pop       = ready_in & ~empty;
  assign valid_out = ~empty;

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
    router_fifo #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push_i (push[k]),
      .pop_i  (pop[k]),
      .data_i (din),
      .full_o (full[k]),
      .empty_o(empty[k]),
      .data_o (dout[port_slice(k, DATA_WIDTH) +: DATA_WIDTH])
    );
  end

`ifdef ROUTER_DROP_CNT_EN
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (valid_in && ready_out && !in_range && (drop_cnt_q != '1))
      drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_router_1xn_buf.sv
// tb/tb_router_1xn_buf.sv - self-checking bench for router_1xn_buf
module tb_router_1xn_buf;

  localparam int DW    = 8;
  localparam int NP    = 4;
  localparam int DEPTH = 4;

  typedef struct {
    logic          v;
    logic [1:0]    a;
    logic [DW-1:0] d;
    logic [NP-1:0] r;
    logic          er;
    logic [NP-1:0] ev;
    int            cp;
    logic [DW-1:0] ed;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   din;
  logic [1:0]      addr;
  logic            valid_in;
  logic            ready_out;
  logic [NP*DW-1:0] dout;
  logic [NP-1:0]   valid_out;
  logic [NP-1:0]   ready_in;

  logic [DW-1:0]   din3;
  logic [1:0]      addr3;
  logic            valid3;
  logic            ready3;
  logic [3*DW-1:0] dout3;
  logic [2:0]      vout3;
  logic [2:0]      rdy3;
`ifdef ROUTER_DROP_CNT_EN
  logic [15:0]     drop_cnt;
  logic [15:0]     drop3;
`endif

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mbuf  [NP][DEPTH];
  int            mcnt  [NP];
  logic [DW-1:0] mlast [NP];
  int            delivered [NP];

  always #5 clk = ~clk;

  router_1xn_buf #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .din(din), .addr(addr), .valid_in(valid_in),
    .ready_out(ready_out), .dout(dout), .valid_out(valid_out), .ready_in(ready_in)
`ifdef ROUTER_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  router_1xn_buf #(.DATA_WIDTH(DW), .NUM_PORTS(3), .FIFO_DEPTH(DEPTH)) dut3 (
    .clk(clk), .rst(rst), .din(din3), .addr(addr3), .valid_in(valid3),
    .ready_out(ready3), .dout(dout3), .valid_out(vout3), .ready_in(rdy3)
`ifdef ROUTER_DROP_CNT_EN
    , .drop_cnt(drop3)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NP; k++) begin
      mcnt[k]  = 0;
      mlast[k] = '0;
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < NP; k++) begin
      chk($sformatf("valid_out[%0d]", k), 32'(valid_out[k]), 32'(mcnt[k] > 0));
      chk($sformatf("dout[%0d]", k), 32'(dout[k*DW +: DW]),
          32'((mcnt[k] > 0) ? mbuf[k][0] : mlast[k]));
    end
  endtask

  // One clock: drive, check ready_out, advance the queue model, check outputs.
  task automatic cycle(input logic v, input logic [1:0] a, input logic [DW-1:0] d,
                       input logic [NP-1:0] r, output logic seen_rdy, output logic acc);
    logic exp_rdy;
    valid_in = v;
    addr     = a;
    din      = d;
    ready_in = r;
    #2;
    seen_rdy = ready_out;
    exp_rdy  = (mcnt[a] < DEPTH);
    chk("ready_out", 32'(ready_out), 32'(exp_rdy));
    acc = v && exp_rdy;
    for (int k = 0; k < NP; k++) begin
      if (mcnt[k] > 0 && r[k]) begin
        mlast[k] = mbuf[k][0];
        for (int j = 1; j < DEPTH; j++) mbuf[k][j-1] = mbuf[k][j];
        mcnt[k]--;
        delivered[k]++;
      end
    end
    if (acc) begin
      mbuf[a][mcnt[a]] = d;
      mcnt[a]++;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl [13];
    logic r_seen;
    logic acc;
    int   sent;
    int   base;

    tbl[0]  = '{1'b1, 2'd2, 8'hA5, 4'hF, 1'b1, 4'b0100, 2, 8'hA5};
    tbl[1]  = '{1'b0, 2'd2, 8'h00, 4'hF, 1'b1, 4'b0000, 2, 8'hA5};
    tbl[2]  = '{1'b1, 2'd1, 8'h01, 4'hD, 1'b1, 4'b0010, 1, 8'h01};
    tbl[3]  = '{1'b1, 2'd1, 8'h02, 4'hD, 1'b1, 4'b0010, 1, 8'h01};
    tbl[4]  = '{1'b1, 2'd1, 8'h03, 4'hD, 1'b1, 4'b0010, 1, 8'h01};
    tbl[5]  = '{1'b1, 2'd1, 8'h04, 4'hD, 1'b1, 4'b0010, 1, 8'h01};
    tbl[6]  = '{1'b1, 2'd1, 8'h05, 4'hD, 1'b0, 4'b0010, 1, 8'h01};
    tbl[7]  = '{1'b1, 2'd0, 8'h10, 4'hD, 1'b1, 4'b0011, 0, 8'h10};
    tbl[8]  = '{1'b0, 2'd1, 8'h00, 4'hD, 1'b0, 4'b0010, 1, 8'h01};
    tbl[9]  = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0010, 1, 8'h02};
    tbl[10] = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0010, 1, 8'h03};
    tbl[11] = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0010, 1, 8'h04};
    tbl[12] = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 1, 8'h04};

    rst = 1'b1; din = '0; addr = '0; valid_in = 1'b0; ready_in = '0;
    din3 = '0; addr3 = '0; valid3 = 1'b0; rdy3 = '0;
    model_reset();
    for (int k = 0; k < NP; k++) delivered[k] = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset ready_out", 32'(ready_out), 32'd0);
    chk("reset valid_out", 32'(valid_out), 32'd0);
    chk("reset dout", 32'(dout), 32'd0);
`ifdef ROUTER_DROP_CNT_EN
    chk("reset drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    rst = 1'b0;
    #2;
    chk("first ready_out addr0", 32'(ready_out), 32'd1);
    addr = 2'd3;
    #1;
    chk("first ready_out addr3", 32'(ready_out), 32'd1);

    // Three-port instance: address 3 is out of range and must be swallowed.
    valid3 = 1'b1; addr3 = 2'd3; din3 = 8'hEE; rdy3 = 3'b111;
    #1;
    chk("oor ready_out", 32'(ready3), 32'd1);
`ifdef ROUTER_DROP_CNT_EN
    chk("oor drop_cnt before", 32'(drop3), 32'd0);
`endif
    @(posedge clk);
    #1;
    chk("oor valid_out", 32'(vout3), 32'd0);
`ifdef ROUTER_DROP_CNT_EN
    chk("oor drop_cnt after", 32'(drop3), 32'd1);
`endif
    addr3 = 2'd2; din3 = 8'h5A;
    #1;
    chk("p3 ready_out addr2", 32'(ready3), 32'd1);
    @(posedge clk);
    #1;
    valid3 = 1'b0;
    chk("p3 valid_out addr2", 32'(vout3), 32'b100);
    chk("p3 dout addr2", 32'(dout3[2*DW +: DW]), 32'h5A);
    @(posedge clk);
    #1;
    chk("p3 drained", 32'(vout3), 32'd0);
`ifdef ROUTER_DROP_CNT_EN
    chk("p3 drop_cnt held", 32'(drop3), 32'd1);
`endif

    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].r, r_seen, acc);
      chk($sformatf("tbl%0d ready_out", i), 32'(r_seen), 32'(tbl[i].er));
      chk($sformatf("tbl%0d valid_out", i), 32'(valid_out), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d dout", i), 32'(dout[tbl[i].cp*DW +: DW]), 32'(tbl[i].ed));
    end

    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, 2'(i % 4), 8'($urandom), 4'hF, r_seen, acc);
      chk("rr accepted", 32'(acc), 32'd1);
    end
    cycle(1'b0, 2'd0, 8'h00, 4'hF, r_seen, acc);

    sent = 0;
    base = delivered[3];
    for (int c = 0; c < 300 && (delivered[3] - base) < 10; c++) begin
      cycle(sent < 10, 2'd3, 8'h30 + 8'(sent), {1'($urandom), 3'b111}, r_seen, acc);
      if (acc) sent++;
    end
    chk("wrap sent", 32'(sent), 32'd10);
    chk("wrap delivered", 32'(delivered[3] - base), 32'd10);

    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, 2'($urandom), 8'($urandom), 4'($urandom), r_seen, acc);

    repeat (6) cycle(1'b0, 2'd0, 8'h00, 4'hF, r_seen, acc);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 2'd0, 8'hC0 + 8'(i), 4'b1110, r_seen, acc);
    chk("queued before reset", 32'(valid_out), 32'b0001);
    valid_in = 1'b0;
    addr     = 2'd0;
    #3;
    rst = 1'b1;
    #1;
    chk("async rst valid_out", 32'(valid_out), 32'd0);
    chk("async rst dout", 32'(dout), 32'd0);
    chk("async rst ready_out", 32'(ready_out), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    chk("post rst ready_out", 32'(ready_out), 32'd1);
    chk("post rst valid_out", 32'(valid_out), 32'd0);
    cycle(1'b0, 2'd0, 8'h00, 4'hF, r_seen, acc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
